// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared between the SPI controller and spi_slave_rx.
//   WORD_W_DEF  - default serial word width
//   spi_state_e - receiver FSM encoding (IDLE, SHIFT)
//   cnt_w()     - bit-counter width for a given word width
package spi_pkg;

  localparam int WORD_W_DEF = 24;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI pins plus word/flag handshake of spi_slave_rx.
//   sen/sclk/sdata        - serial pins (SEN active low)
//   word_out/word_valid   - received word, valid/ready with word_ready
//   busy/overrun/frame_err- status (flags sticky)
//   clr_flags             - one-cycle pulse clearing the sticky flags
// modport slave  : receiver side
// modport master : pin driver / word consumer side
interface spi_slave_rx_if #(
  parameter int WORD_W = spi_pkg::WORD_W_DEF
);
  logic              sen;
  logic              sclk;
  logic              sdata;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic              busy;
  logic              overrun;
  logic              frame_err;
  logic              clr_flags;

  modport slave (
    input  sen, sclk, sdata, word_ready, clr_flags,
    output word_out, word_valid, busy, overrun, frame_err
  );

  modport master (
    output sen, sclk, sdata, word_ready, clr_flags,
    input  word_out, word_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/spi_sync.sv
// spi_sync: STAGES-deep flop synchronizer with configurable reset value.
//   clk_i, rst_i (async, active high), d_i async input, q_o synchronized.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {STAGES{RST_VAL}};
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling SPI receiver, rebuilds MSB-first words and
// hands them out on a valid/ready port; reports overrun/frame errors.
//   clock, reset (async, active high)
//   bus (spi_slave_rx_if.slave): SEN/SCLK/SDATA pins, word_out/valid/ready,
//     busy, overrun, frame_err, clr_flags
// Optional: define SPI_RX_FRAME_CHECK_EN to enable frame_err detection
// (partial word at SEN rise, SCLK rise while idle); otherwise frame_err = 0.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic     clock,
  input logic     reset,
  spi_slave_rx_if.slave bus
);

  localparam int CW = cnt_w(WORD_W);

  logic sen_s, sclk_s, sdata_s, sclk_q, sclk_rise;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sen (
    .clk_i(clock), .rst_i(reset), .d_i(bus.sen), .q_o(sen_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(clock), .rst_i(reset), .d_i(bus.sclk), .q_o(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (
    .clk_i(clock), .rst_i(reset), .d_i(bus.sdata), .q_o(sdata_s));

  assign sclk_rise = sclk_s & ~sclk_q;

  spi_state_e        state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d, word_q, word_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d, valid_q, valid_d, ovr_q, ovr_d;
  logic              drain, ovr_set;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!sen_s) state_d = SHIFT;
      SHIFT:   if (sen_s)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    drain   = valid_q & bus.word_ready;

    // Idle keeps the assembler empty so a partial word never leaks out.
    if (state_q == IDLE) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (sclk_rise) begin
      shift_d = {shift_q[WORD_W-2:0], sdata_s};
      if (cnt_q == CW'(WORD_W-1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // done_q trails the final shift by one cycle; shift_q still holds the
    // full word here (any idle clear lands on this same edge).
    if (done_q) begin
      if (!valid_q || drain) begin
        word_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end

    ovr_d = (ovr_q & ~bus.clr_flags) | ovr_set;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sclk_q  <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_s;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SPI_RX_FRAME_CHECK_EN
  logic ferr_q, ferr_set;

  assign ferr_set = ((state_q == SHIFT) && sen_s && (cnt_q != '0)) ||
                    ((state_q == IDLE) && sclk_rise);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ferr_q <= 1'b0;
    else       ferr_q <= (ferr_q & ~bus.clr_flags) | ferr_set;
  end

  assign bus.frame_err = ferr_q;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spi_slave_rx_if #(.WORD_W(24)) bus ();

  spi_slave_rx #(.WORD_W(24), .SYNC_STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] rxq[$];

  // Capture every accepted word at the handshake edge.
  always @(posedge clock)
    if (!reset && bus.word_valid && bus.word_ready) rxq.push_back(bus.word_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One SCLK period: 8 clocks low (data set up), 8 clocks high.
  task automatic send_bit(input logic b);
    bus.sdata = b;
    ticks(8);
    bus.sclk = 1'b1;
    ticks(8);
    bus.sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  logic [23:0] wB;
  int lat;

  initial begin
    bus.sen = 1'b1; bus.sclk = 1'b0; bus.sdata = 1'b0;
    bus.word_ready = 1'b1; bus.clr_flags = 1'b0;
    ticks(3);
    chk("rst_word_out", bus.word_out, 24'h0);
    chk("rst_valid", bus.word_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_overrun", bus.overrun, 1'b0);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    reset = 1'b0;
    ticks(5);

    // Single word, with busy and end-to-end latency timing.
    bus.sen = 1'b0;
    ticks(2);
    chk("busy_lat_early", bus.busy, 1'b0);
    ticks(1);
    chk("busy_lat_3", bus.busy, 1'b1);
    send_bits(24'hA5C3F0 >> 1, 23);
    bus.sdata = 1'b0;
    ticks(8);
    bus.sclk = 1'b1;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (lat < 0 && bus.word_valid) lat = i;
    end
    bus.sclk = 1'b0;
    chk("valid_latency", lat, 4);
    bus.sen = 1'b1;
    ticks(10);
    chk("t1_count", rxq.size(), 1);
    if (rxq.size() > 0) chk("t1_word", rxq[0], 24'hA5C3F0);
    chk("t1_overrun", bus.overrun, 1'b0);
    chk("t1_frame_err", bus.frame_err, 1'b0);
    chk("t1_busy_off", bus.busy, 1'b0);
    rxq.delete();

    // Three words in one frame, ready held high.
    bus.sen = 1'b0;
    send_bits(24'h0019AC, 24);
    chk("t2_busy_w1", bus.busy, 1'b1);
    send_bits(24'hFFA5A5, 24);
    chk("t2_busy_w2", bus.busy, 1'b1);
    send_bits(24'hF0ABCD, 24);
    chk("t2_busy_w3", bus.busy, 1'b1);
    bus.sen = 1'b1;
    ticks(10);
    chk("t2_count", rxq.size(), 3);
    if (rxq.size() == 3) begin
      chk("t2_word0", rxq[0], 24'h0019AC);
      chk("t2_word1", rxq[1], 24'hFFA5A5);
      chk("t2_word2", rxq[2], 24'hF0ABCD);
    end
    chk("t2_overrun", bus.overrun, 1'b0);
    rxq.delete();

    // Same words, ready low: overrun and hold.
    bus.word_ready = 1'b0;
    bus.sen = 1'b0;
    send_bits(24'h0019AC, 24);
    chk("t3_valid_w1", bus.word_valid, 1'b1);
    chk("t3_ovr_w1", bus.overrun, 1'b0);
    send_bits(24'hFFA5A5, 24);
    chk("t3_ovr_w2", bus.overrun, 1'b1);
    chk("t3_hold_w2", bus.word_out, 24'h0019AC);
    send_bits(24'hF0ABCD, 24);
    bus.sen = 1'b1;
    ticks(10);
    chk("t3_hold_w3", bus.word_out, 24'h0019AC);
    bus.clr_flags = 1'b1;
    ticks(1);
    bus.clr_flags = 1'b0;
    ticks(1);
    chk("t3_ovr_clr", bus.overrun, 1'b0);
    chk("t3_word_after_clr", bus.word_out, 24'h0019AC);
    chk("t3_valid_after_clr", bus.word_valid, 1'b1);
    bus.word_ready = 1'b1;
    ticks(2);
    chk("t3_drained", bus.word_valid, 1'b0);
    chk("t3_drain_count", rxq.size(), 1);
    if (rxq.size() > 0) chk("t3_drain_word", rxq[0], 24'h0019AC);
    rxq.delete();

    // Partial word (10 bits) then a full one.
    bus.sen = 1'b0;
    send_bits(24'h0003FF, 10);
    bus.sen = 1'b1;
    ticks(10);
    chk("t4_no_partial", rxq.size(), 0);
`ifdef SPI_RX_FRAME_CHECK_EN
    chk("t4_frame_err", bus.frame_err, 1'b1);
`else
    chk("t4_frame_err", bus.frame_err, 1'b0);
`endif
    bus.clr_flags = 1'b1;
    ticks(1);
    bus.clr_flags = 1'b0;
    ticks(1);
    chk("t4_ferr_clr", bus.frame_err, 1'b0);
    bus.sen = 1'b0;
    send_bits(24'h123456, 24);
    bus.sen = 1'b1;
    ticks(10);
    chk("t4_count", rxq.size(), 1);
    if (rxq.size() > 0) chk("t4_word", rxq[0], 24'h123456);
    chk("t4_ferr_full", bus.frame_err, 1'b0);
    rxq.delete();

    // Reset after 12 bits of a word.
    bus.sen = 1'b0;
    send_bits(24'hABC, 12);
    reset = 1'b1;
    #1;
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_word_out", bus.word_out, 24'h0);
    chk("t5_valid", bus.word_valid, 1'b0);
    bus.sen = 1'b1;
    ticks(3);
    reset = 1'b0;
    ticks(5);
    bus.sen = 1'b0;
    send_bits(24'h654321, 24);
    bus.sen = 1'b1;
    ticks(10);
    chk("t5_count", rxq.size(), 1);
    if (rxq.size() > 0) chk("t5_word", rxq[0], 24'h654321);
    rxq.delete();

    // ready arrives exactly as word B completes while A is held.
    bus.word_ready = 1'b0;
    bus.sen = 1'b0;
    send_bits(24'hABCDEF, 24);
    chk("t6_a_held", bus.word_out, 24'hABCDEF);
    wB = 24'h13579B;
    send_bits(wB >> 1, 23);
    bus.sdata = wB[0];
    ticks(8);
    bus.sclk = 1'b1;
    ticks(3);
    bus.word_ready = 1'b1;
    ticks(1);
    bus.word_ready = 1'b0;
    chk("t6_word_b", bus.word_out, 24'h13579B);
    chk("t6_valid_b", bus.word_valid, 1'b1);
    chk("t6_overrun", bus.overrun, 1'b0);
    chk("t6_a_count", rxq.size(), 1);
    if (rxq.size() > 0) chk("t6_a_word", rxq[0], 24'hABCDEF);
    ticks(4);
    bus.sclk = 1'b0;
    bus.sen = 1'b1;
    bus.word_ready = 1'b1;
    ticks(10);
    chk("t6_b_count", rxq.size(), 2);
    if (rxq.size() > 1) chk("t6_b_word", rxq[1], 24'h13579B);
    chk("t6_overrun_end", bus.overrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
